atom_msg_serializer: RTL and testbench

- Serializes one typed integer-atom message per transaction into a byte stream.
- Message kinds: byte, shortint, int, longint.
- Sits directly downstream of the typed-parameter producer modules (IntegerAtomTypes-style ports) and upstream of the byte-wide link/FIFO.
- Emits an optional header byte carrying the kind, then the payload bytes LSB first, then an optional XOR checksum byte.

---
 rtl/atom_msg_pkg.sv | 31 +++
 rtl/atom_msg_serializer_if.sv | 27 ++
 rtl/atom_msg_serializer.sv | 155 +++++++++++++++
 tb/tb_atom_msg_serializer.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/atom_msg_pkg.sv
// Shared types for the integer-atom message serializer: atom kinds,
// serializer FSM states and the kind-to-payload-length helper.
package atom_msg_pkg;

  typedef enum logic [1:0] {
    KIND_BYTE     = 2'd0,
    KIND_SHORTINT = 2'd1,
    KIND_INT      = 2'd2,
    KIND_LONGINT  = 2'd3
  } atom_kind_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HDR  = 2'd1,
    ST_DATA = 2'd2,
    ST_CSUM = 2'd3
  } ser_state_e;

  // Payload length in bytes for each atom kind.
  function automatic logic [3:0] kind_nbytes(atom_kind_e kind);
    logic [3:0] n;
    case (kind)
      KIND_BYTE:     n = 4'd1;
      KIND_SHORTINT: n = 4'd2;
      KIND_INT:      n = 4'd4;
      default:       n = 4'd8;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/atom_msg_serializer_if.sv
// Message-in / byte-out handshake bundle for the atom serializer.
// master = producer/consumer side (testbench or neighbours), slave = serializer.
interface atom_msg_serializer_if;
  import atom_msg_pkg::*;

  logic       in_valid;
  logic       in_ready;
  atom_kind_e in_kind;
  logic [63:0] in_data;

  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic       out_sof;
  logic       out_eof;

  modport master (
    output in_valid, in_kind, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_sof, out_eof
  );

  modport slave (
    input  in_valid, in_kind, in_data, out_ready,
    output in_ready, out_valid, out_data, out_sof, out_eof
  );

endinterface

// File: rtl/atom_msg_serializer.sv
// Serializes one typed integer atom per transaction into a byte stream:
// optional kind header, payload bytes LSB first, optional XOR checksum.
// All stream outputs come straight from registers.
module atom_msg_serializer
  import atom_msg_pkg::*;
#(
  parameter bit HDR_EN  = 1'b1,
  parameter bit CSUM_EN = 1'b1,
  parameter int COUNT_W = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  atom_msg_serializer_if.slave bus,
  output logic [COUNT_W-1:0]  msg_count
);

  localparam logic [1:0] S_IDLE = ST_IDLE;
  localparam logic [1:0] S_HDR  = ST_HDR;
  localparam logic [1:0] S_DATA = ST_DATA;
  localparam logic [1:0] S_CSUM = ST_CSUM;

  logic [1:0]         state_q, state_d;
  atom_kind_e         kind_q, kind_d;
  logic [63:0]        data_q, data_d;
  logic [2:0]         idx_q, idx_d;
  logic [7:0]         csum_q, csum_d;
  logic [7:0]         byte_q, byte_d;
  logic               sof_q, sof_d;
  logic               eof_q, eof_d;
  logic               valid_q, valid_d;
  logic [COUNT_W-1:0] count_q, count_d;

  logic [7:0] fold;
  logic [2:0] lastIdx;
  logic [2:0] idxNext;

  // Next-state logic: each transition also precomputes the byte and framing
  // flags for the following beat so the outputs can be pure registers.
  always_comb begin
    state_d = state_q;
    kind_d  = kind_q;
    data_d  = data_q;
    idx_d   = idx_q;
    csum_d  = csum_q;
    byte_d  = byte_q;
    sof_d   = sof_q;
    eof_d   = eof_q;
    valid_d = valid_q;
    count_d = count_q;
    fold    = csum_q ^ byte_q;
    lastIdx = 3'(kind_nbytes(kind_q) - 4'd1);
    idxNext = idx_q + 3'd1;

    case (state_q)
      S_IDLE: begin
        if (bus.in_valid) begin
          kind_d  = bus.in_kind;
          data_d  = bus.in_data;
          csum_d  = 8'h00;
          idx_d   = 3'd0;
          valid_d = 1'b1;
          sof_d   = 1'b1;
          if (HDR_EN) begin
            state_d = S_HDR;
            byte_d  = {6'b0, bus.in_kind};
            eof_d   = 1'b0;
          end else begin
            state_d = S_DATA;
            byte_d  = bus.in_data[7:0];
            eof_d   = (kind_nbytes(bus.in_kind) == 4'd1) && !CSUM_EN;
          end
        end
      end
      S_HDR: begin
        if (bus.out_ready) begin
          csum_d  = fold;
          state_d = S_DATA;
          byte_d  = data_q[7:0];
          sof_d   = 1'b0;
          eof_d   = (lastIdx == 3'd0) && !CSUM_EN;
        end
      end
      S_DATA: begin
        if (bus.out_ready) begin
          csum_d = fold;
          sof_d  = 1'b0;
          if (idx_q == lastIdx) begin
            if (CSUM_EN) begin
              state_d = S_CSUM;
              byte_d  = fold;
              eof_d   = 1'b1;
            end else begin
              state_d = S_IDLE;
              valid_d = 1'b0;
              byte_d  = 8'h00;
              eof_d   = 1'b0;
              count_d = count_q + 1'b1;
            end
          end else begin
            idx_d  = idxNext;
            byte_d = data_q[{idxNext, 3'b000} +: 8];
            eof_d  = (idxNext == lastIdx) && !CSUM_EN;
          end
        end
      end
      S_CSUM: begin
        if (bus.out_ready) begin
          state_d = S_IDLE;
          valid_d = 1'b0;
          byte_d  = 8'h00;
          sof_d   = 1'b0;
          eof_d   = 1'b0;
          count_d = count_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State, held message and output registers; reset drops any message in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      kind_q  <= KIND_BYTE;
      data_q  <= 64'h0;
      idx_q   <= 3'd0;
      csum_q  <= 8'h00;
      byte_q  <= 8'h00;
      sof_q   <= 1'b0;
      eof_q   <= 1'b0;
      valid_q <= 1'b0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      kind_q  <= kind_d;
      data_q  <= data_d;
      idx_q   <= idx_d;
      csum_q  <= csum_d;
      byte_q  <= byte_d;
      sof_q   <= sof_d;
      eof_q   <= eof_d;
      valid_q <= valid_d;
      count_q <= count_d;
    end
  end

  // in_ready is masked by reset so the block never advertises space while held in reset.
  assign bus.in_ready  = rst_n && (state_q == S_IDLE);
  assign bus.out_valid = valid_q;
  assign bus.out_data  = byte_q;
  assign bus.out_sof   = sof_q;
  assign bus.out_eof   = eof_q;
  assign msg_count     = count_q;

endmodule

// File: tb/tb_atom_msg_serializer.sv
// Scoreboard bench for atom_msg_serializer: three instances cover the default
// framing, the bare (no header, no checksum) framing and a 2-bit counter.
module tb_atom_msg_serializer;
  import atom_msg_pkg::*;

  typedef struct packed {
    logic [7:0] data;
    logic       sof;
    logic       eof;
  } beat_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic        inValid[3];
  logic [1:0]  inKind[3];
  logic [63:0] inData[3];
  logic        outReady[3];
  logic        inReady[3];
  logic        outValid[3];
  logic [7:0]  outData[3];
  logic        outSof[3];
  logic        outEof[3];
  logic [15:0] msgCount[3];

  bit          hdrEn[3];
  bit          csumEn[3];
  logic [15:0] cntMask[3];
  int          readyMode[3];

  beat_t       expQ[3][$];
  logic [15:0] expCount[3];
  int          popCount[3];
  int          hsCycle[3];
  int          sofCycle[3];
  int          eofCycle[3];
  int          span[3];
  int          gap[3];
  bit          prevHold[3];
  logic [9:0]  prevBeat[3];

  int cycle = 0;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Free-running cycle counter used for latency and spacing measurements.
  always @(posedge clk) cycle <= cycle + 1;

  for (genvar g = 0; g < 3; g++) begin : gInst
    atom_msg_serializer_if bus ();

    assign bus.in_valid  = inValid[g];
    assign bus.in_kind   = atom_kind_e'(inKind[g]);
    assign bus.in_data   = inData[g];
    assign bus.out_ready = outReady[g];
    assign inReady[g]    = bus.in_ready;
    assign outValid[g]   = bus.out_valid;
    assign outData[g]    = bus.out_data;
    assign outSof[g]     = bus.out_sof;
    assign outEof[g]     = bus.out_eof;

    if (g == 0) begin : gDefault
      logic [15:0] cnt;
      atom_msg_serializer #(.HDR_EN(1'b1), .CSUM_EN(1'b1), .COUNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus), .msg_count(cnt)
      );
      assign msgCount[g] = cnt;
    end else if (g == 1) begin : gBare
      logic [15:0] cnt;
      atom_msg_serializer #(.HDR_EN(1'b0), .CSUM_EN(1'b0), .COUNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus), .msg_count(cnt)
      );
      assign msgCount[g] = cnt;
    end else begin : gSmallCount
      logic [1:0] cnt;
      atom_msg_serializer #(.HDR_EN(1'b1), .CSUM_EN(1'b1), .COUNT_W(2)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus), .msg_count(cnt)
      );
      assign msgCount[g] = {14'b0, cnt};
    end
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: observed %0h expected %0h (t=%0t)", tag, observed, expected, $time);
    end
  endtask

  // Per-instance output monitor: backpressure stability, busy in_ready, beat scoreboard.
  task automatic checkBeat(input int i);
    beat_t exp;
    if (!rst_n) begin
      prevHold[i] = 1'b0;
      return;
    end
    if (outValid[i])
      checkOutput($sformatf("in_ready_busy[%0d]", i), 64'(inReady[i]), 64'd0);
    if (prevHold[i])
      checkOutput($sformatf("hold[%0d]", i), 64'({outData[i], outSof[i], outEof[i]}), 64'(prevBeat[i]));
    prevHold[i] = outValid[i] && !outReady[i];
    prevBeat[i] = {outData[i], outSof[i], outEof[i]};
    if (outValid[i] && outReady[i]) begin
      if (expQ[i].size() == 0) begin
        checkOutput($sformatf("unexpected_beat[%0d]", i), 64'(outData[i]), 64'h1ff);
      end else begin
        exp = expQ[i].pop_front();
        checkOutput($sformatf("beat[%0d]", i), 64'({outData[i], outSof[i], outEof[i]}), 64'(exp));
        checkOutput($sformatf("count_at_beat[%0d]", i), 64'(msgCount[i]), 64'(expCount[i]));
        popCount[i]++;
        if (exp.sof) begin
          gap[i] = cycle - eofCycle[i];
          sofCycle[i] = cycle;
        end
        if (exp.eof) begin
          span[i] = cycle - sofCycle[i];
          eofCycle[i] = cycle;
          expCount[i] = (expCount[i] + 16'd1) & cntMask[i];
        end
      end
    end
  endtask

  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) checkBeat(i);
  end

  // Ready driver: constant high or toggling every cycle.
  always @(posedge clk) begin
    #1;
    for (int i = 0; i < 3; i++)
      outReady[i] = (readyMode[i] == 1) ? ~outReady[i] : 1'b1;
  end

  // Present one message, wait for acceptance and push its expected beats.
  task automatic applyStimulus(input int i, input logic [1:0] kind, input logic [63:0] data, input bit keep);
    bit hs;
    int n;
    logic [7:0] cs;
    logic [7:0] b;
    inKind[i] = kind;
    inData[i] = data;
    inValid[i] = 1'b1;
    hs = 1'b0;
    for (int c = 0; c < 200 && !hs; c++) begin
      @(negedge clk);
      if (inReady[i]) hs = 1'b1;
    end
    if (!hs) begin
      checkOutput($sformatf("handshake_timeout[%0d]", i), 64'd0, 64'd1);
      inValid[i] = 1'b0;
      return;
    end
    hsCycle[i] = cycle;
    n = 1 << kind;
    cs = 8'h00;
    if (hdrEn[i]) begin
      b = {6'b0, kind};
      expQ[i].push_back('{data: b, sof: 1'b1, eof: 1'b0});
      cs ^= b;
    end
    for (int k = 0; k < n; k++) begin
      b = data[8*k +: 8];
      expQ[i].push_back('{data: b, sof: (!hdrEn[i] && k == 0), eof: (!csumEn[i] && k == n - 1)});
      cs ^= b;
    end
    if (csumEn[i]) expQ[i].push_back('{data: cs, sof: 1'b0, eof: 1'b1});
    @(posedge clk);
    #1;
    inValid[i] = keep;
    if (!keep) inData[i] = ~data;
  endtask

  // Wait (bounded) for all expected beats, then check the settled counter.
  task automatic waitDrain(input int i, input int maxCycles);
    for (int c = 0; c < maxCycles && expQ[i].size() != 0; c++) @(negedge clk);
    checkOutput($sformatf("drain[%0d]", i), 64'(expQ[i].size()), 64'd0);
    @(posedge clk);
    #1;
    checkOutput($sformatf("msg_count[%0d]", i), 64'(msgCount[i]), 64'(expCount[i]));
  endtask

  task automatic clearModel();
    for (int i = 0; i < 3; i++) begin
      expQ[i].delete();
      expCount[i] = 16'd0;
      prevHold[i] = 1'b0;
    end
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int base;
    logic [15:0] wrapSeq[5];
    wrapSeq = '{16'd1, 16'd2, 16'd3, 16'd0, 16'd1};
    hdrEn   = '{1'b1, 1'b0, 1'b1};
    csumEn  = '{1'b1, 1'b0, 1'b1};
    cntMask = '{16'hFFFF, 16'hFFFF, 16'h0003};
    for (int i = 0; i < 3; i++) begin
      inValid[i] = 1'b0; inKind[i] = 2'd0; inData[i] = 64'h0;
      outReady[i] = 1'b1; readyMode[i] = 0;
      popCount[i] = 0; hsCycle[i] = 0; sofCycle[i] = 0; eofCycle[i] = 0;
      span[i] = 0; gap[i] = 0; prevBeat[i] = 10'h0;
    end
    clearModel();

    // Power-on reset values.
    #17;
    checkOutput("rst_out_valid", 64'(outValid[0]), 64'd0);
    checkOutput("rst_out_data", 64'(outData[0]), 64'd0);
    checkOutput("rst_sof_eof", 64'({outSof[0], outEof[0]}), 64'd0);
    checkOutput("rst_msg_count", 64'(msgCount[0]), 64'd0);
    checkOutput("rst_in_ready", 64'(inReady[0]), 64'd0);
    checkOutput("rst_in_ready_bare", 64'(inReady[1]), 64'd0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    #1 checkOutput("in_ready_after_release", 64'(inReady[0]), 64'd1);
    @(posedge clk);
    #1;

    // INT with header and checksum, six consecutive beats.
    applyStimulus(0, 2'd2, 64'h0000_0000_DEAD_BEEF, 1'b0);
    waitDrain(0, 50);
    checkOutput("int_span", 64'(span[0]), 64'd5);
    checkOutput("int_latency", 64'(sofCycle[0] - hsCycle[0]), 64'd1);

    // Bare BYTE: a single beat with sof and eof together, one cycle after handshake.
    applyStimulus(1, 2'd0, 64'hFFFF_FFFF_FFFF_FFA5, 1'b0);
    waitDrain(1, 50);
    checkOutput("byte_latency", 64'(sofCycle[1] - hsCycle[1]), 64'd1);
    checkOutput("byte_span", 64'(span[1]), 64'd0);

    // Bare SHORTINT for a multi-byte payload without framing bytes.
    applyStimulus(1, 2'd1, 64'h0000_0000_0000_C3D4, 1'b0);
    waitDrain(1, 50);

    // LONGINT under alternating backpressure.
    readyMode[0] = 1;
    applyStimulus(0, 2'd3, 64'h0807_0605_0403_0201, 1'b0);
    waitDrain(0, 100);
    readyMode[0] = 0;
    @(posedge clk);
    #1;

    // Back-to-back messages with in_valid held: one bubble between them.
    applyStimulus(0, 2'd1, 64'h0000_0000_0000_1234, 1'b1);
    applyStimulus(0, 2'd0, 64'h0000_0000_0000_0055, 1'b0);
    waitDrain(0, 50);
    checkOutput("bubble_gap", 64'(gap[0]), 64'd2);
    checkOutput("count_after_b2b", 64'(msgCount[0]), 64'd4);

    // Reset in the middle of a LONGINT.
    base = popCount[0];
    applyStimulus(0, 2'd3, 64'h1122_3344_5566_7788, 1'b0);
    for (int c = 0; c < 100 && popCount[0] < base + 3; c++) @(negedge clk);
    checkOutput("third_beat_seen", 64'(popCount[0] >= base + 3), 64'd1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("midrst_out_valid", 64'(outValid[0]), 64'd0);
    checkOutput("midrst_msg_count", 64'(msgCount[0]), 64'd0);
    checkOutput("midrst_in_ready", 64'(inReady[0]), 64'd0);
    clearModel();
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    #1 checkOutput("in_ready_after_midrst", 64'(inReady[0]), 64'd1);
    checkOutput("out_valid_after_midrst", 64'(outValid[0]), 64'd0);
    @(posedge clk);
    #1;
    applyStimulus(0, 2'd0, 64'h0000_0000_0000_0001, 1'b0);
    waitDrain(0, 50);

    // Two-bit counter wraps without saturating.
    for (int m = 0; m < 5; m++) begin
      applyStimulus(2, 2'd0, 64'(32'h40 + m), 1'b0);
      waitDrain(2, 50);
      checkOutput($sformatf("wrap_seq_%0d", m), 64'(msgCount[2]), 64'(wrapSeq[m]));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
